player_collision: RTL and testbench

- Downstream consumer of the player block's is_player_hitbox, sampled alongside the obstacle layer's per-pixel hitbox during the OLED pixel scan.
- Accumulates per-frame overlap, applies lives and post-hit grace, and produces collision, lives and game-over status for the game controller, LEDs and display.

---
 rtl/player_collision_pkg.sv | 24 ++
 rtl/frame_wrap_detect.sv | 44 ++++
 rtl/player_collision.sv | 127 ++++++++++++
 tb/tb_player_collision.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_collision_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_collision_pkg                                                 |
// | Shared frame geometry, collision FSM encodings and helpers.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package player_collision_pkg;

  localparam int c_OLED_WIDTH   = 96;
  localparam int c_OLED_HEIGHT  = 64;
  localparam int c_FRAME_PIXELS = c_OLED_WIDTH * c_OLED_HEIGHT;
  localparam int c_INDEX_W      = 13;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ALIVE = 2'd1;
  localparam logic [1:0] c_GRACE = 2'd2;
  localparam logic [1:0] c_OVER  = 2'd3;

  function automatic logic [2:0] sat_dec_lives(input logic [2:0] value);
    return (value == 3'd0) ? 3'd0 : value - 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_wrap_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_wrap_detect                                                    |
// | Tracks the last in-frame scan index and pulses frame_tick on wrap.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_wrap_detect
  import player_collision_pkg::*;
#(
  parameter int FRAME_PIXELS = c_FRAME_PIXELS,
  parameter int INDEX_W      = c_INDEX_W
) (
  input  logic               clock_100mhz,
  input  logic               reset,
  input  logic [INDEX_W-1:0] pixel_index,
  output logic               index_valid,
  output logic               wrap_now,
  output logic               frame_tick
);

  localparam logic [INDEX_W:0] c_LIMIT = (INDEX_W + 1)'(FRAME_PIXELS);

  logic [INDEX_W-1:0] r_prev_index;
  logic               r_frame_tick;

  // Out-of-range indices (blanking) neither wrap nor move the reference.
  assign index_valid = {1'b0, pixel_index} < c_LIMIT;
  assign wrap_now    = index_valid && (pixel_index < r_prev_index);
  assign frame_tick  = r_frame_tick;

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      r_prev_index <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= wrap_now;
      if (index_valid) begin
        r_prev_index <= pixel_index;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/player_collision.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_collision                                                     |
// | Per-frame player/obstacle overlap, lives, grace and game-over.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module player_collision
  import player_collision_pkg::*;
#(
  parameter int FRAME_PIXELS = c_FRAME_PIXELS,
  parameter int START_LIVES  = 3,
  parameter int GRACE_FRAMES = 60,
  parameter int FLASH_BIT    = 3
) (
  input  logic        clock_100mhz,
  input  logic        reset,
  input  logic [12:0] pixel_index,
  input  logic        game_active,
  input  logic        is_player_hitbox,
  input  logic        is_obstacle_hitbox,
  output logic        collision_pulse,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic        in_grace,
  output logic        hit_flash,
  output logic        frame_tick
);

  localparam logic [2:0] c_START_LIVES  = 3'(START_LIVES);
  localparam logic [7:0] c_GRACE_FRAMES = 8'(GRACE_FRAMES);

  logic [1:0] r_state;
  logic [2:0] r_lives;
  logic       r_overlap_flag;
  logic [7:0] r_grace_cnt;
  logic       r_collision_pulse;

  logic       w_index_valid;
  logic       w_wrap;
  logic       w_pixel_overlap;
  logic [2:0] w_lives_dec;
  logic [7:0] w_grace_next;

  frame_wrap_detect #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .INDEX_W      (13)
  ) u_frame_wrap_detect (
    .clock_100mhz (clock_100mhz),
    .reset        (reset),
    .pixel_index  (pixel_index),
    .index_valid  (w_index_valid),
    .wrap_now     (w_wrap),
    .frame_tick   (frame_tick)
  );

  assign w_pixel_overlap = w_index_valid & is_player_hitbox & is_obstacle_hitbox;
  assign w_lives_dec     = sat_dec_lives(r_lives);
  assign w_grace_next    = (r_grace_cnt == 8'd0) ? 8'd0 : r_grace_cnt - 8'd1;

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      r_state           <= c_IDLE;
      r_lives           <= c_START_LIVES;
      r_overlap_flag    <= 1'b0;
      r_grace_cnt       <= 8'd0;
      r_collision_pulse <= 1'b0;
    end else begin
      r_collision_pulse <= 1'b0;
      if (r_state != c_IDLE && !game_active) begin
        r_state        <= c_IDLE;
        r_lives        <= c_START_LIVES;
        r_overlap_flag <= 1'b0;
        r_grace_cnt    <= 8'd0;
      end else begin
        // The wrap pixel opens the new frame, so it reloads rather than ORs.
        if (r_state == c_IDLE) begin
          r_overlap_flag <= 1'b0;
        end else if (w_wrap) begin
          r_overlap_flag <= w_pixel_overlap;
        end else begin
          r_overlap_flag <= r_overlap_flag | w_pixel_overlap;
        end

        case (r_state)
          c_IDLE: begin
            r_lives     <= c_START_LIVES;
            r_grace_cnt <= 8'd0;
            if (game_active) begin
              r_state <= c_ALIVE;
            end
          end
          c_ALIVE: begin
            if (w_wrap && r_overlap_flag) begin
              r_lives           <= w_lives_dec;
              r_collision_pulse <= 1'b1;
              if (w_lives_dec == 3'd0) begin
                r_state <= c_OVER;
              end else begin
                r_state     <= c_GRACE;
                r_grace_cnt <= c_GRACE_FRAMES;
              end
            end
          end
          c_GRACE: begin
            if (w_wrap) begin
              r_grace_cnt <= w_grace_next;
              if (w_grace_next == 8'd0) begin
                r_state <= c_ALIVE;
              end
            end
          end
          default: begin
            r_lives <= 3'd0;
          end
        endcase
      end
    end
  end

  assign collision_pulse = r_collision_pulse;
  assign lives           = r_lives;
  assign game_over       = (r_state == c_OVER);
  assign in_grace        = (r_state == c_GRACE);
  assign hit_flash       = (r_state == c_GRACE) & r_grace_cnt[FLASH_BIT];

endmodule
`default_nettype wire

// File: tb/tb_player_collision.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_player_collision                                                  |
// | Scoreboarded bench: expected pulses queued per wrap, popped on pulse.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_player_collision;

  localparam int FP = 96;

  logic        clock_100mhz = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] pixel_index = 13'd0;
  logic        game_active_main = 1'b0;
  logic        game_active_g2 = 1'b0;
  logic        is_player_hitbox = 1'b0;
  logic        is_obstacle_hitbox = 1'b0;

  logic       m_pulse, m_over, m_grace, m_flash, m_tick;
  logic [2:0] m_lives;
  logic       g_pulse, g_over, g_grace, g_flash, g_tick;
  logic [2:0] g_lives;

  always #5 clock_100mhz = ~clock_100mhz;

  player_collision #(
    .FRAME_PIXELS(FP), .START_LIVES(3), .GRACE_FRAMES(60), .FLASH_BIT(3)
  ) dut (
    .clock_100mhz(clock_100mhz), .reset(reset), .pixel_index(pixel_index),
    .game_active(game_active_main), .is_player_hitbox(is_player_hitbox),
    .is_obstacle_hitbox(is_obstacle_hitbox), .collision_pulse(m_pulse),
    .lives(m_lives), .game_over(m_over), .in_grace(m_grace),
    .hit_flash(m_flash), .frame_tick(m_tick)
  );

  player_collision #(
    .FRAME_PIXELS(FP), .START_LIVES(3), .GRACE_FRAMES(2), .FLASH_BIT(3)
  ) dut_g2 (
    .clock_100mhz(clock_100mhz), .reset(reset), .pixel_index(pixel_index),
    .game_active(game_active_g2), .is_player_hitbox(is_player_hitbox),
    .is_obstacle_hitbox(is_obstacle_hitbox), .collision_pulse(g_pulse),
    .lives(g_lives), .game_over(g_over), .in_grace(g_grace),
    .hit_flash(g_flash), .frame_tick(g_tick)
  );

  typedef struct {
    int         wrap;
    logic [2:0] lives;
  } exp_t;

  exp_t q_main[$];
  exp_t q_g2[$];
  int checks = 0;
  int errors = 0;
  int wraps = 0;
  int last_pix = 0;
  int m_ticks = 0;
  int g_ticks = 0;

  // One scan cycle; outputs sampled 1 ns after the edge that consumed the inputs.
  task automatic step(input int pix, input logic ply, input logic obs);
    exp_t e;
    pixel_index        = 13'(pix);
    is_player_hitbox   = ply;
    is_obstacle_hitbox = obs;
    @(posedge clock_100mhz);
    #1;
    if (reset) begin
      last_pix = 0;
    end else if (pix < FP) begin
      if (pix < last_pix) wraps++;
      last_pix = pix;
    end
    if (m_tick) m_ticks++;
    if (g_tick) g_ticks++;
    if (m_pulse) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL main_pulse: unexpected pulse at wrap %0d lives %0d, expected none", wraps, m_lives);
      end else begin
        e = q_main.pop_front();
        if (e.wrap != wraps || m_lives !== e.lives) begin
          errors++;
          $display("FAIL main_pulse: wrap %0d lives %0d, expected wrap %0d lives %0d", wraps, m_lives, e.wrap, e.lives);
        end
      end
    end
    if (g_pulse) begin
      checks++;
      if (q_g2.size() == 0) begin
        errors++;
        $display("FAIL g2_pulse: unexpected pulse at wrap %0d lives %0d, expected none", wraps, g_lives);
      end else begin
        e = q_g2.pop_front();
        if (e.wrap != wraps || g_lives !== e.lives) begin
          errors++;
          $display("FAIL g2_pulse: wrap %0d lives %0d, expected wrap %0d lives %0d", wraps, g_lives, e.wrap, e.lives);
        end
      end
    end
  endtask

  // Player spans 20..29, obstacles 40..49: no overlap except at hit_pix.
  task automatic scan(input int from, input int hit_pix, input int hit_len);
    for (int p = from; p < FP; p++) begin
      if (p == hit_pix) begin
        repeat (hit_len) step(p, 1'b1, 1'b1);
      end else begin
        step(p, (p >= 20 && p < 30), (p >= 40 && p < 50));
      end
      if (p == 50) begin
        step(200, 1'b1, 1'b1);
        step(8191, 1'b1, 1'b1);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1);
    checks++;
    if (m_lives !== 3'd3) begin
      errors++;
      $display("FAIL reset_lives: got %0d expected 3", m_lives);
    end
    checks++;
    if ({m_pulse, m_over, m_grace, m_flash, m_tick} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {m_pulse, m_over, m_grace, m_flash, m_tick});
    end
    checks++;
    if (g_lives !== 3'd3 || {g_pulse, g_over, g_grace, g_flash, g_tick} !== 5'b0) begin
      errors++;
      $display("FAIL reset_g2: lives %0d flags %b expected 3 00000", g_lives, {g_pulse, g_over, g_grace, g_flash, g_tick});
    end
    reset = 1'b0;
  endtask

  task automatic test_no_overlap;
    int t0;
    game_active_main = 1'b1;
    step(0, 1'b0, 1'b0);
    t0 = m_ticks;
    scan(0, -1, 0);
    scan(0, -1, 0);
    scan(0, -1, 0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (m_ticks - t0 != 3) begin
      errors++;
      $display("FAIL no_overlap_ticks: got %0d expected 3", m_ticks - t0);
    end
    checks++;
    if (m_lives !== 3'd3 || m_grace !== 1'b0 || m_over !== 1'b0) begin
      errors++;
      $display("FAIL no_overlap_state: lives %0d grace %b over %b expected 3 0 0", m_lives, m_grace, m_over);
    end
  endtask

  task automatic test_grace_flash;
    logic exp_flash;
    q_main.push_back('{wraps + 1, 3'd2});
    scan(1, 60, 20);
    for (int k = 0; k <= 60; k++) begin
      step(0, 1'b0, 1'b0);
      exp_flash = (k < 60) ? 1'((60 - k) >> 3) : 1'b0;
      checks++;
      if (m_grace !== (k < 60)) begin
        errors++;
        $display("FAIL grace_level: frame %0d got %b expected %b", k, m_grace, (k < 60));
      end
      checks++;
      if (m_flash !== exp_flash) begin
        errors++;
        $display("FAIL grace_flash: frame %0d got %b expected %b", k, m_flash, exp_flash);
      end
      scan(1, (k < 60) ? 60 : -1, 1);
    end
    step(0, 1'b0, 1'b0);
    checks++;
    if (m_lives !== 3'd2 || q_main.size() != 0) begin
      errors++;
      $display("FAIL grace_end: lives %0d pending %0d expected 2 0", m_lives, q_main.size());
    end
  endtask

  task automatic test_drop_mid_grace;
    q_main.push_back('{wraps + 1, 3'd1});
    scan(1, 60, 1);
    step(0, 1'b0, 1'b0);
    scan(1, 60, 1);
    for (int p = 0; p <= 70; p++) step(p, (p == 60), (p == 60));
    checks++;
    if (m_lives !== 3'd1 || m_grace !== 1'b1 || m_flash !== 1'b1) begin
      errors++;
      $display("FAIL drop_before: lives %0d grace %b flash %b expected 1 1 1", m_lives, m_grace, m_flash);
    end
    game_active_main = 1'b0;
    step(71, 1'b0, 1'b0);
    checks++;
    if (m_lives !== 3'd3 || {m_grace, m_flash, m_over} !== 3'b000) begin
      errors++;
      $display("FAIL drop_idle: lives %0d grace/flash/over %b expected 3 000", m_lives, {m_grace, m_flash, m_over});
    end
    for (int p = 72; p <= 75; p++) step(p, 1'b1, 1'b1);
    game_active_main = 1'b1;
    for (int p = 76; p < FP; p++) step(p, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (m_lives !== 3'd3 || m_grace !== 1'b0) begin
      errors++;
      $display("FAIL drop_reenable: lives %0d grace %b expected 3 0", m_lives, m_grace);
    end
    q_main.push_back('{wraps + 1, 3'd2});
    scan(1, 60, 1);
    step(0, 1'b0, 1'b0);
    checks++;
    if (m_grace !== 1'b1 || q_main.size() != 0) begin
      errors++;
      $display("FAIL drop_clean_hit: grace %b pending %0d expected 1 0", m_grace, q_main.size());
    end
  endtask

  task automatic test_game_over_g2;
    game_active_main = 1'b0;
    game_active_g2   = 1'b1;
    step(0, 1'b0, 1'b0);
    q_g2.push_back('{wraps + 1, 3'd2});
    q_g2.push_back('{wraps + 4, 3'd1});
    q_g2.push_back('{wraps + 7, 3'd0});
    scan(1, 60, 1);
    for (int r = 1; r <= 9; r++) begin
      step(0, 1'b0, 1'b0);
      if (r == 1) begin
        checks++;
        if (g_grace !== 1'b1 || g_flash !== 1'b0) begin
          errors++;
          $display("FAIL g2_grace: grace %b flash %b expected 1 0", g_grace, g_flash);
        end
      end
      scan(1, 60, 1);
    end
    step(0, 1'b0, 1'b0);
    checks++;
    if (g_over !== 1'b1 || g_lives !== 3'd0 || q_g2.size() != 0) begin
      errors++;
      $display("FAIL g2_over: over %b lives %0d pending %0d expected 1 0 0", g_over, g_lives, q_g2.size());
    end
    game_active_g2 = 1'b0;
    step(1, 1'b0, 1'b0);
    checks++;
    if (g_over !== 1'b0 || g_lives !== 3'd3) begin
      errors++;
      $display("FAIL g2_leave_over: over %b lives %0d expected 0 3", g_over, g_lives);
    end
  endtask

  task automatic test_frame_boundaries;
    game_active_main = 1'b1;
    step(1, 1'b0, 1'b0);
    q_main.push_back('{wraps + 1, 3'd2});
    scan(2, FP - 1, 1);
    step(0, 1'b0, 1'b0);
    checks++;
    if (q_main.size() != 0 || m_lives !== 3'd2) begin
      errors++;
      $display("FAIL last_pixel: pending %0d lives %0d expected 0 2", q_main.size(), m_lives);
    end
    game_active_main = 1'b0;
    step(1, 1'b0, 1'b0);
    game_active_main = 1'b1;
    step(2, 1'b0, 1'b0);
    scan(3, -1, 0);
    q_main.push_back('{wraps + 2, 3'd2});
    step(0, 1'b1, 1'b1);
    scan(1, -1, 0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (q_main.size() != 0 || m_lives !== 3'd2) begin
      errors++;
      $display("FAIL first_pixel: pending %0d lives %0d expected 0 2", q_main.size(), m_lives);
    end
  endtask

  task automatic test_reset_on_tick;
    game_active_main = 1'b0;
    step(1, 1'b0, 1'b0);
    game_active_main = 1'b1;
    step(2, 1'b0, 1'b0);
    scan(3, 60, 1);
    reset = 1'b1;
    step(0, 1'b0, 1'b0);
    reset = 1'b0;
    checks++;
    if (m_pulse !== 1'b0 || m_tick !== 1'b0 || m_lives !== 3'd3 || m_grace !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick: pulse %b tick %b lives %0d grace %b expected 0 0 3 0", m_pulse, m_tick, m_lives, m_grace);
    end
    step(0, 1'b0, 1'b0);
    scan(1, -1, 0);
    step(0, 1'b0, 1'b0);
    checks++;
    if (m_lives !== 3'd3 || m_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume: lives %0d over %b expected 3 0", m_lives, m_over);
    end
  endtask

  initial begin
    test_reset();
    test_no_overlap();
    test_grace_flash();
    test_drop_mid_grace();
    test_game_over_g2();
    test_frame_boundaries();
    test_reset_on_tick();
    checks++;
    if (m_ticks != wraps || g_ticks != wraps) begin
      errors++;
      $display("FAIL tick_count: main %0d g2 %0d expected %0d", m_ticks, g_ticks, wraps);
    end
    checks++;
    if (q_main.size() != 0 || q_g2.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: main %0d g2 %0d expected 0 0", q_main.size(), q_g2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
